// File: rtl/game_pkg.sv
// Shared types and constants for the memory-game sequencer.
// Holds the state encoding, LFSR taps, counter widths and BCD folding.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    ENTRY  = 2'd2,
    RESULT = 2'd3
  } gameState_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DIGIT_CNT_W = 3;
  localparam logic [DIGIT_CNT_W-1:0] DIGITS_MAX = 3'd4;
  localparam int TICK_CNT_W = 8;

  function automatic logic [3:0] bcdFold(input logic [3:0] n);
    return (n > 4'd9) ? (n - 4'd10) : n;
  endfunction

endpackage

// File: rtl/lfsr_bcd16.sv
// Free-running 16-bit Fibonacci LFSR with a four-digit BCD view of its state.
// The BCD view folds any nibble above 9 back into the 0..9 range.
module lfsr_bcd16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        fastClk,
  input  logic        rst,
  output logic [15:0] bcdValue
);

  logic [15:0] lfsr;

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign bcdValue = {bcdFold(lfsr[15:12]), bcdFold(lfsr[11:8]),
                     bcdFold(lfsr[7:4]),   bcdFold(lfsr[3:0])};

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer for a number-memory game: show a random BCD target,
// collect four player digits, compare, and keep a saturating score.
//
// state  | meaning
// IDLE   | waiting for start; target and last result held
// SHOW   | target displayed for SHOW_TICKS blink ticks
// ENTRY  | collecting up to four digits until submit or timeout
// RESULT | result displayed for RESULT_TICKS blink ticks
module game_sequencer
  import game_pkg::*;
#(
  parameter int          SHOW_TICKS   = 6,
  parameter int          ENTRY_TICKS  = 40,
  parameter int          RESULT_TICKS = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        fastClk,
  input  logic        rst,
  input  logic        blinkTick,
  input  logic        start,
  input  logic [3:0]  digitIn,
  input  logic        digitValid,
  input  logic        submit,
  output logic        displayPhase,
  output logic [15:0] randInt,
  output logic [15:0] userInput,
  output logic        inputReady,
  output logic        correct,
  output logic [7:0]  score,
  output logic [1:0]  state
);

  localparam logic [TICK_CNT_W-1:0] SHOW_LAST   = TICK_CNT_W'(SHOW_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] ENTRY_LAST  = TICK_CNT_W'(ENTRY_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] RESULT_LAST = TICK_CNT_W'(RESULT_TICKS - 1);

  gameState_t             stateQ, stateNext;
  logic [TICK_CNT_W-1:0]  tickCnt, tickNext;
  logic [DIGIT_CNT_W-1:0] digitCnt, digitCntNext;
  logic [15:0]            randNext, userNext, bcdValue;
  logic                   correctNext, digitOk, submitOk, isMatch;
  logic [7:0]             scoreNext;

  lfsr_bcd16 #(.SEED(LFSR_SEED)) uLfsr (
    .fastClk  (fastClk),
    .rst      (rst),
    .bcdValue (bcdValue)
  );

  assign isMatch = (userInput == randInt);

  always_comb begin
    stateNext    = stateQ;
    tickNext     = tickCnt;
    digitCntNext = digitCnt;
    randNext     = randInt;
    userNext     = userInput;
    correctNext  = correct;
    scoreNext    = score;
    digitOk      = 1'b0;
    submitOk     = 1'b0;
    case (stateQ)
      IDLE: begin
        userNext = '0;
        if (start) begin
          stateNext    = SHOW;
          randNext     = bcdValue;
          tickNext     = '0;
          digitCntNext = '0;
        end
      end
      SHOW: begin
        if (blinkTick) begin
          if (tickCnt == SHOW_LAST) begin
            stateNext    = ENTRY;
            tickNext     = '0;
            userNext     = '0;
            digitCntNext = '0;
          end else begin
            tickNext = tickCnt + 1'b1;
          end
        end
      end
      ENTRY: begin
        // A submit before four digits is simply dropped, so a simultaneous
        // digit strobe resolves naturally by the current count.
        digitOk  = digitValid && (digitIn <= 4'd9) && (digitCnt < DIGITS_MAX);
        submitOk = submit && (digitCnt == DIGITS_MAX);
        if (digitOk) begin
          userNext     = {userInput[11:0], digitIn};
          digitCntNext = digitCnt + 1'b1;
        end
        if (blinkTick) tickNext = tickCnt + 1'b1;
        if (submitOk) begin
          stateNext   = RESULT;
          tickNext    = '0;
          correctNext = isMatch;
          if (isMatch && (score != 8'hFF)) scoreNext = score + 8'd1;
        end else if (blinkTick && (tickCnt == ENTRY_LAST)) begin
          stateNext   = RESULT;
          tickNext    = '0;
          correctNext = 1'b0;
        end
      end
      RESULT: begin
        if (start) begin
          stateNext    = SHOW;
          randNext     = bcdValue;
          tickNext     = '0;
          digitCntNext = '0;
          userNext     = '0;
        end else if (blinkTick) begin
          if (tickCnt == RESULT_LAST) begin
            stateNext = IDLE;
            tickNext  = '0;
            userNext  = '0;
          end else begin
            tickNext = tickCnt + 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      stateQ       <= IDLE;
      tickCnt      <= '0;
      digitCnt     <= '0;
      randInt      <= '0;
      userInput    <= '0;
      correct      <= 1'b0;
      score        <= '0;
      displayPhase <= 1'b0;
      inputReady   <= 1'b0;
    end else begin
      stateQ       <= stateNext;
      tickCnt      <= tickNext;
      digitCnt     <= digitCntNext;
      randInt      <= randNext;
      userInput    <= userNext;
      correct      <= correctNext;
      score        <= scoreNext;
      displayPhase <= (stateNext == SHOW);
      inputReady   <= (stateNext == RESULT);
    end
  end

  assign state = stateQ;

endmodule

// File: tb/tb_game_sequencer.sv
// Scenario bench for game_sequencer: an independent LFSR model predicts the
// target, and expected round results are queued at submit time.
module tb_game_sequencer;

  localparam int          SHOW_T   = 6;
  localparam int          ENTRY_T  = 40;
  localparam int          RESULT_T = 4;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic        fastClk = 1'b0;
  logic        rst = 1'b1;
  logic        blinkTick = 1'b0, start = 1'b0, digitValid = 1'b0, submit = 1'b0;
  logic [3:0]  digitIn = 4'd0;
  logic        displayPhase, inputReady, correct;
  logic [15:0] randInt, userInput;
  logic [7:0]  score;
  logic [1:0]  state;

  typedef struct {
    logic        corr;
    logic [7:0]  sc;
    logic [15:0] ui;
    logic [15:0] ri;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] expRand;
  logic [7:0]  expScore;
  logic [15:0] mLfsr;

  game_sequencer #(
    .SHOW_TICKS(SHOW_T), .ENTRY_TICKS(ENTRY_T),
    .RESULT_TICKS(RESULT_T), .LFSR_SEED(SEED)
  ) dut (
    .fastClk(fastClk), .rst(rst), .blinkTick(blinkTick), .start(start),
    .digitIn(digitIn), .digitValid(digitValid), .submit(submit),
    .displayPhase(displayPhase), .randInt(randInt), .userInput(userInput),
    .inputReady(inputReady), .correct(correct), .score(score), .state(state)
  );

  always #5 fastClk = ~fastClk;

  always @(posedge fastClk or posedge rst) begin
    if (rst) mLfsr <= SEED;
    else     mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
  end

  function automatic logic [15:0] bcdMap(input logic [15:0] v);
    logic [15:0] r;
    logic [3:0]  nib;
    r = v;
    for (int i = 0; i < 4; i++) begin
      nib = v[4*i +: 4];
      if (nib > 4'd9) nib = nib - 4'd10;
      r[4*i +: 4] = nib;
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge fastClk);
    #1;
  endtask

  task automatic tickPulse();
    blinkTick = 1'b1; cyc(); blinkTick = 1'b0; cyc();
  endtask

  task automatic enterDigit(input logic [3:0] d, input logic withSubmit);
    digitIn = d; digitValid = 1'b1; submit = withSubmit;
    cyc();
    digitValid = 1'b0; submit = 1'b0;
  endtask

  task automatic pressSubmit();
    submit = 1'b1; cyc(); submit = 1'b0;
  endtask

  task automatic pushExp(input logic c, input logic [15:0] ui);
    exp_t e;
    e.corr = c; e.sc = expScore; e.ui = ui; e.ri = expRand;
    sbq.push_back(e);
  endtask

  task automatic checkResult(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (inputReady !== 1'b1 && n < 20) begin cyc(); n++; end
    checks++;
    if (inputReady !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL %s result wait: inputReady=%b queued=%0d required inputReady=1 with a queued entry",
               tag, inputReady, sbq.size());
      return;
    end
    e = sbq.pop_front();
    checks++;
    if ({state, displayPhase, correct, score, userInput, randInt} !==
        {2'd3, 1'b0, e.corr, e.sc, e.ui, e.ri}) begin
      errors++;
      $display("FAIL %s result: state=%0d disp=%b correct=%b score=%0d user=%h rand=%h required state=3 disp=0 correct=%b score=%0d user=%h rand=%h",
               tag, state, displayPhase, correct, score, userInput, randInt,
               e.corr, e.sc, e.ui, e.ri);
    end
  endtask

  task automatic startRound(input string tag);
    start = 1'b1;
    expRand = bcdMap(mLfsr);
    cyc();
    start = 1'b0;
    checks++;
    if ({state, displayPhase, inputReady, randInt} !== {2'd1, 1'b1, 1'b0, expRand}) begin
      errors++;
      $display("FAIL %s start: state=%0d disp=%b ready=%b rand=%h required state=1 disp=1 ready=0 rand=%h",
               tag, state, displayPhase, inputReady, randInt, expRand);
    end
  endtask

  task automatic showTicks(input string tag);
    repeat (SHOW_T - 1) tickPulse();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL %s show early: state=%0d required 1", tag, state);
    end
    tickPulse();
    checks++;
    if ({state, displayPhase, inputReady, userInput} !== {2'd2, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL %s enter entry: state=%0d disp=%b ready=%b user=%h required state=2 disp=0 ready=0 user=0000",
               tag, state, displayPhase, inputReady, userInput);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    checks++;
    if ({state, displayPhase, inputReady, correct, score, randInt, userInput} !== '0) begin
      errors++;
      $display("FAIL reset: state=%0d disp=%b ready=%b correct=%b score=%0d rand=%h user=%h required all zero",
               state, displayPhase, inputReady, correct, score, randInt, userInput);
    end
    rst = 1'b0;
    expScore = 8'd0;
    cyc();
  endtask

  task automatic test_correct_round();
    startRound("correct");
    showTicks("correct");
    for (int i = 3; i >= 0; i--) enterDigit(expRand[4*i +: 4], 1'b0);
    expScore = expScore + 8'd1;
    pushExp(1'b1, expRand);
    pressSubmit();
    checkResult("correct");
  endtask

  task automatic test_wrong_round();
    logic [3:0] d;
    startRound("wrong");
    showTicks("wrong");
    d = (expRand == 16'h9999) ? 4'd0 : 4'd9;
    repeat (4) enterDigit(d, 1'b0);
    pushExp(1'b0, {4{d}});
    pressSubmit();
    checkResult("wrong");
  endtask

  task automatic test_partial_entry();
    startRound("partial");
    showTicks("partial");
    enterDigit(4'd1, 1'b0); enterDigit(4'd2, 1'b0); enterDigit(4'd3, 1'b0);
    pressSubmit();
    checks++;
    if ({state, inputReady, userInput} !== {2'd2, 1'b0, 16'h0123}) begin
      errors++;
      $display("FAIL early submit: state=%0d ready=%b user=%h required state=2 ready=0 user=0123",
               state, inputReady, userInput);
    end
    enterDigit(4'hA, 1'b0);
    checks++;
    if (userInput !== 16'h0123) begin
      errors++;
      $display("FAIL non-bcd digit: user=%h required 0123", userInput);
    end
    enterDigit(4'd4, 1'b1);
    checks++;
    if ({state, userInput} !== {2'd2, 16'h1234}) begin
      errors++;
      $display("FAIL digit with submit: state=%0d user=%h required state=2 user=1234", state, userInput);
    end
    enterDigit(4'd5, 1'b0);
    checks++;
    if (userInput !== 16'h1234) begin
      errors++;
      $display("FAIL fifth digit: user=%h required 1234", userInput);
    end
    if (expRand == 16'h1234) expScore = expScore + 8'd1;
    pushExp(expRand == 16'h1234, 16'h1234);
    pressSubmit();
    checkResult("partial");
  endtask

  task automatic test_timeout();
    startRound("timeout");
    showTicks("timeout");
    start = 1'b1; cyc(); start = 1'b0;
    checks++;
    if ({state, randInt} !== {2'd2, expRand}) begin
      errors++;
      $display("FAIL start in entry: state=%0d rand=%h required state=2 rand=%h", state, randInt, expRand);
    end
    repeat (ENTRY_T - 1) tickPulse();
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL entry early: state=%0d required 2", state);
    end
    pushExp(1'b0, 16'h0000);
    tickPulse();
    checkResult("timeout");
    repeat (RESULT_T - 1) tickPulse();
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL result early: state=%0d required 3", state);
    end
    tickPulse();
    checks++;
    if ({state, displayPhase, inputReady, userInput, randInt, correct, score} !==
        {2'd0, 1'b0, 1'b0, 16'h0, expRand, 1'b0, expScore}) begin
      errors++;
      $display("FAIL idle: state=%0d disp=%b ready=%b user=%h rand=%h correct=%b score=%0d required state=0 disp=0 ready=0 user=0000 rand=%h correct=0 score=%0d",
               state, displayPhase, inputReady, userInput, randInt, correct, score, expRand, expScore);
    end
    tickPulse();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL tick in idle: state=%0d required 0", state);
    end
  endtask

  task automatic test_reset_mid();
    startRound("midreset");
    showTicks("midreset");
    enterDigit(4'd1, 1'b0); enterDigit(4'd2, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({state, displayPhase, inputReady, correct, score, randInt, userInput} !== '0) begin
      errors++;
      $display("FAIL async reset: state=%0d disp=%b ready=%b correct=%b score=%0d rand=%h user=%h required all zero",
               state, displayPhase, inputReady, correct, score, randInt, userInput);
    end
    cyc();
    rst = 1'b0;
    expScore = 8'd0;
    cyc();
    startRound("after reset");
  endtask

  initial begin
    test_reset();
    test_correct_round();
    test_wrong_round();
    test_partial_entry();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter SHOW_TICKS, 6, number of blinkTick pulses spent in SHOW.
REQ-002 SHALL have parameter ENTRY_TICKS, 40, number of blinkTick pulses allowed in ENTRY before timeout.
REQ-003 SHALL have parameter RESULT_TICKS, 4, number of blinkTick pulses spent in RESULT.
REQ-004 SHALL have parameter LFSR_SEED, 16'hACE1, LFSR value loaded at reset.
REQ-005 fastClk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 blinkTick  input  1  single-cycle pulse, fastClk-synchronous, one per blink period.
REQ-008 start  input  1  single-cycle pulse requesting a new round.
REQ-009 digitIn  input  4  BCD digit entered by the player.
REQ-010 digitValid  input  1  single-cycle strobe qualifying digitIn.
REQ-011 submit  input  1  single-cycle strobe ending entry.
REQ-012 displayPhase  output  1  high while the target number is shown.
REQ-013 randInt  output  16  target number, four BCD digits, MSD in [15:12].
REQ-014 userInput  output  16  player entry, four BCD digits, MSD in [15:12].
REQ-015 inputReady  output  1  high while the result is shown.
REQ-016 correct  output  1  result of the last comparison.
REQ-017 score  output  8  count of correct rounds, saturating.
REQ-018 state  output  2  current FSM state, for debug.

Function
REQ-019 FSM states SHALL be IDLE=0, SHOW=1, ENTRY=2, RESULT=3; all outputs SHALL be registered.
REQ-020 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every fastClk cycle in all states.
REQ-021 On start in IDLE or RESULT: randInt SHALL load the BCD-mapped LFSR (each nibble n>9 becomes n-10); tick counter SHALL clear; next state SHALL be SHOW.
REQ-022 In SHOW: displayPhase=1 and inputReady=0; on the SHOW_TICKS-th blinkTick, next state SHALL be ENTRY with userInput=0 and digit count=0.
REQ-023 In ENTRY, digitValid with digitIn<=9 and count<4 SHALL shift userInput left by 4 bits, insert digitIn at [3:0], and increment count; all other digitValid SHALL be ignored.
REQ-024 In ENTRY, submit with count==4 SHALL go to RESULT with correct=(userInput==randInt); submit with count<4 SHALL be ignored.
REQ-025 Simultaneous digitValid and submit SHALL be treated as digitValid alone when count<4, and as submit alone when count==4.
REQ-026 In ENTRY, the ENTRY_TICKS-th blinkTick without an accepted submit SHALL go to RESULT with correct=0; an accepted submit in the same cycle SHALL take priority.
REQ-027 On every entry to RESULT with correct=1, score SHALL increment by 1 and saturate at 255.
REQ-028 In RESULT: inputReady=1 and displayPhase=0; on the RESULT_TICKS-th blinkTick, next state SHALL be IDLE; start SHALL take priority over the tick.
REQ-029 In IDLE: displayPhase=0, inputReady=0, userInput=0; randInt and correct SHALL hold their values.
REQ-030 start SHALL be ignored in SHOW and ENTRY; blinkTick SHALL be ignored in IDLE.

Reset
REQ-031 rst SHALL force state=IDLE, LFSR=LFSR_SEED, randInt=0, userInput=0, displayPhase=0, inputReady=0, correct=0, score=0, and clear the tick and digit counters.
REQ-032 rst asserted mid-round SHALL abort the round with no score change.

Structure
REQ-033 The state encoding, the LFSR tap constant, and the digit count width SHALL be defined in a shared package game_pkg.
REQ-034 The LFSR plus BCD mapping SHALL be one sub-module, lfsr_bcd16.

Verification
REQ-035 Reset, then start; after SHOW_TICKS ticks, enter the four digits of randInt and submit -> inputReady=1, correct=1, score=1.
REQ-036 Same round, enter 9,9,9,9 with randInt!=16'h9999 and submit -> correct=0, score unchanged.
REQ-037 In ENTRY, enter 1,2,3 then submit -> ignored; then 4, 5 (fifth digit ignored) and submit -> userInput=16'h1234.
REQ-038 In ENTRY, digitIn=4'hA with digitValid -> userInput and count unchanged.
REQ-039 No submit for ENTRY_TICKS ticks -> RESULT with correct=0; after RESULT_TICKS ticks -> IDLE.
REQ-040 Assert rst during ENTRY -> all outputs at reset values in the same cycle; a following start yields a new SHOW.
